// File: rtl/riscv_core_divctrl.sv
// riscv_core_divctrl: multi-cycle sequencer for the RV32M divide/remainder path.
// The datapath is a radix-2 restoring divider that retires one quotient bit per clock.
// Divide-by-zero and signed overflow finish without iterating.
// busy is a pure state decode that the hazard unit can use as a stall request.
module riscv_core_divctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_divctrl_start,
  input  logic [1:0]      i_divctrl_op,
  input  logic [XLEN-1:0] i_divctrl_a,
  input  logic [XLEN-1:0] i_divctrl_b,
  input  logic            i_divctrl_flush,
  output logic            o_divctrl_busy,
  output logic            o_divctrl_valid,
  output logic [XLEN-1:0] o_divctrl_result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            negQuo_q, negQuo_d;
  logic            negRem_q, negRem_d;

  logic            accept;
  logic            isSigned;
  logic            aNeg;
  logic            bNeg;
  logic [XLEN-1:0] aMag;
  logic [XLEN-1:0] bMag;
  logic            divZero;
  logic            overflow;

  logic [XLEN:0]   remShift;
  logic [XLEN+1:0] trial;
  logic            noBorrow;
  logic [XLEN-1:0] nextRem;
  logic [XLEN-1:0] nextQuo;

  logic [XLEN-1:0] finalQuo;
  logic [XLEN-1:0] finalRem;
  logic [XLEN-1:0] doneResult;

  // Decode the incoming request: magnitudes, signs and the two early-exit cases.
  always_comb begin
    isSigned = ~i_divctrl_op[0];
    aNeg     = isSigned & i_divctrl_a[XLEN-1];
    bNeg     = isSigned & i_divctrl_b[XLEN-1];
    aMag     = aNeg ? (XLEN'(0) - i_divctrl_a) : i_divctrl_a;
    bMag     = bNeg ? (XLEN'(0) - i_divctrl_b) : i_divctrl_b;
    divZero  = (i_divctrl_b == '0);
    overflow = isSigned
               & (i_divctrl_a == {1'b1, {(XLEN-1){1'b0}}})
               & (i_divctrl_b == {XLEN{1'b1}});
    accept   = (state_q == IDLE) & i_divctrl_start & ~i_divctrl_flush;
  end

  // One restoring step. The shifted remainder can need XLEN+1 bits when the divisor
  // is a large unsigned value, so the trial subtract is carried at XLEN+2 bits.
  // A non-negative difference always fits in XLEN bits, so its top two bits are zero.
  always_comb begin
    remShift = {rem_q, quo_q[XLEN-1]};
    trial    = {1'b0, remShift} - {2'b00, divisor_q};
    noBorrow = (trial[XLEN+1:XLEN] == 2'b00);
    nextRem  = noBorrow ? trial[XLEN-1:0] : remShift[XLEN-1:0];
    nextQuo  = {quo_q[XLEN-2:0], noBorrow};
  end

  // Apply the sign rules to the finished magnitudes and pick quotient or remainder.
  always_comb begin
    finalQuo   = negQuo_q ? (XLEN'(0) - quo_q) : quo_q;
    finalRem   = negRem_q ? (XLEN'(0) - rem_q) : rem_q;
    doneResult = op_q[1] ? finalRem : finalQuo;
  end

  // Next-state and output decode for the sequencer.
  always_comb begin
    state_d          = state_q;
    o_divctrl_busy   = (state_q == CALC);
    o_divctrl_valid  = 1'b0;
    o_divctrl_result = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (divZero | overflow) ? DONE : CALC;
        end
      end
      CALC: begin
        if (i_divctrl_flush) begin
          state_d = IDLE;
        end else if (count_q == CW'(XLEN-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d         = IDLE;
        o_divctrl_valid = ~i_divctrl_flush;
        if (!i_divctrl_flush) begin
          o_divctrl_result = doneResult;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: load on accept, iterate in CALC, commit the result on leaving DONE.
  always_comb begin
    count_d   = count_q;
    op_d      = op_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    negQuo_d  = negQuo_q;
    negRem_d  = negRem_q;
    if (accept) begin
      op_d    = i_divctrl_op;
      count_d = '0;
      if (divZero) begin
        quo_d     = {XLEN{1'b1}};
        rem_d     = i_divctrl_a;
        divisor_d = '0;
        negQuo_d  = 1'b0;
        negRem_d  = 1'b0;
      end else if (overflow) begin
        quo_d     = i_divctrl_a;
        rem_d     = '0;
        divisor_d = '0;
        negQuo_d  = 1'b0;
        negRem_d  = 1'b0;
      end else begin
        quo_d     = aMag;
        rem_d     = '0;
        divisor_d = bMag;
        negQuo_d  = aNeg ^ bNeg;
        negRem_d  = aNeg;
      end
    end else if ((state_q == CALC) && !i_divctrl_flush) begin
      quo_d   = nextQuo;
      rem_d   = nextRem;
      count_d = count_q + CW'(1);
    end else if ((state_q == DONE) && !i_divctrl_flush) begin
      result_d = doneResult;
    end
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      negQuo_q  <= negQuo_d;
      negRem_q  <= negRem_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_divctrl.sv
// tb_riscv_core_divctrl: directed and random checks of the divide sequencer.
// Expected results come from plain SystemVerilog division with the RISC-V special cases.
module tb_riscv_core_divctrl;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        flush = 1'b0;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] lastResult = 32'h0;

  riscv_core_divctrl #(.XLEN(32)) dut (
    .i_clk            (clk),
    .i_rst_n          (rstN),
    .i_divctrl_start  (start),
    .i_divctrl_op     (op),
    .i_divctrl_a      (a),
    .i_divctrl_b      (b),
    .i_divctrl_flush  (flush),
    .o_divctrl_busy   (busy),
    .o_divctrl_valid  (valid),
    .o_divctrl_result (result)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Reference result from arithmetic rules, not from the divider algorithm.
  function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = x;
      r = 32'h0;
    end else if (!o[0]) begin
      q = 32'($signed(x) / $signed(y));
      r = 32'($signed(x) % $signed(y));
    end else begin
      q = x / y;
      r = x % y;
    end
    return o[1] ? r : q;
  endfunction

  // Cycles from the accepting edge to the valid sample.
  function automatic int refLatency(input logic [1:0] o, input logic [31:0] x,
                                    input logic [31:0] y);
    if (y == 32'h0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for valid, then check latency, result, busy and hold.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit pokeMid, input string tag);
    int          cycles;
    int          busyCycles;
    logic [31:0] exp;
    int          expLat;
    exp    = refResult(o, x, y);
    expLat = refLatency(o, x, y);
    op     = o;
    a      = x;
    b      = y;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    cycles     = 1;
    busyCycles = 0;
    while (valid !== 1'b1 && cycles < 60) begin
      if (busy === 1'b1) busyCycles++;
      if (pokeMid && cycles == 5) begin
        op    = 2'b01;
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    checkOutput({tag, "_valid"}, 32'(valid), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, "_result"}, result, exp);
    checkOutput({tag, "_busycycles"}, 32'(busyCycles), 32'(expLat - 1));
    lastResult = exp;
    @(posedge clk);
    #1;
    checkOutput({tag, "_pulse"}, 32'(valid), 32'd0);
    checkOutput({tag, "_hold"}, result, exp);
  endtask

  // Linear sequence of directed steps followed by random traffic.
  initial begin
    bit          sawValid;
    logic [1:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;
    int          sel;

    #1 rstN = 1'b0;
    #3;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_result", result, 32'h0);
    #8 rstN = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(2'b01, 32'd100, 32'd7, 1'b0, "divu_100_7");
    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, "remu_100_7");
    applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem_m7_2");
    applyStimulus(2'b01, 32'd5, 32'd0, 1'b0, "divu_div0");
    applyStimulus(2'b10, 32'd5, 32'd0, 1'b0, "rem_div0");
    applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "divu_bigdiv");
    applyStimulus(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "remu_bigdiv");
    applyStimulus(2'b01, 32'd100, 32'd7, 1'b1, "divu_startignored");

    // Flush on the 10th CALC cycle.
    op    = 2'b01;
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    checkOutput("flushcalc_prebusy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flushcalc_busy", 32'(busy), 32'd0);
    checkOutput("flushcalc_valid", 32'(valid), 32'd0);
    checkOutput("flushcalc_result", result, lastResult);
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("flushcalc_novalid", 32'(sawValid), 32'd0);
    applyStimulus(2'b01, 32'd9, 32'd3, 1'b0, "divu_9_3");

    // Flush during the DONE cycle of an early-exit op.
    op    = 2'b01;
    a     = 32'd5;
    b     = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("flushdone_prevalid", 32'(valid), 32'd1);
    checkOutput("flushdone_preresult", result, 32'hFFFF_FFFF);
    flush = 1'b1;
    #1;
    checkOutput("flushdone_valid", 32'(valid), 32'd0);
    checkOutput("flushdone_result", result, lastResult);
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flushdone_after", result, lastResult);
    checkOutput("flushdone_busy", 32'(busy), 32'd0);

    // Flush together with start in IDLE drops the start.
    op    = 2'b01;
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flushidle_busy", 32'(busy), 32'd0);
    sawValid = 1'b0;
    repeat (36) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 || busy === 1'b1) sawValid = 1'b1;
    end
    checkOutput("flushidle_noactivity", 32'(sawValid), 32'd0);
    checkOutput("flushidle_result", result, lastResult);

    // Asynchronous reset on the 5th CALC cycle.
    op    = 2'b01;
    a     = 32'd12345;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midreset_prebusy", 32'(busy), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_valid", 32'(valid), 32'd0);
    checkOutput("midreset_result", result, 32'h0);
    lastResult = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postreset_busy", 32'(busy), 32'd0);
    applyStimulus(2'b01, 32'd8, 32'd2, 1'b0, "divu_8_2");

    // Random traffic with a bias toward the corner cases.
    for (int i = 0; i < 24; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom;
      rB  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        rB = 32'h0;
      end else if (sel == 1) begin
        rA = 32'h8000_0000;
        rB = 32'hFFFF_FFFF;
      end else if (sel == 2) begin
        rB = 32'($urandom_range(1, 15));
      end else if (sel == 3) begin
        rB = 32'h0 - 32'($urandom_range(1, 15));
      end
      applyStimulus(rOp, rA, rB, (i % 5) == 2, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
